// File: rtl/bcd_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_alu_sequencer
// Purpose  : Multi-cycle packed-BCD arithmetic engine. Runs add, subtract,
//            multiply (repeated addition) and divide (repeated subtraction)
//            through one shared digit-serial BCD adder, one digit per cycle.
// Ports    : clock       - system clock, rising edge
//            resetn      - asynchronous active-low reset
//            start       - one-cycle execute strobe, sampled in IDLE only
//            op_code     - 00 add, 01 subtract, 10 multiply, 11 divide
//            a_bcd/b_bcd - packed-BCD operands, digit 0 in bits [3:0]
//            busy        - high whenever the engine is not IDLE
//            done        - one-cycle completion pulse (DONE state)
//            result_bcd  - packed-BCD result magnitude, held until next DONE
//            negative    - subtract result is negative
//            overflow    - add/multiply result exceeded 10^DIGITS-1
//            error       - divide by zero
// Revision : 1.0 - initial release
// ============================================================================
module bcd_alu_sequencer #(
   parameter int DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [1:0]            op_code,
   input  logic [4*DIGITS-1:0]   a_bcd,
   input  logic [4*DIGITS-1:0]   b_bcd,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result_bcd,
   output logic                  negative,
   output logic                  overflow,
   output logic                  error
);

   localparam int c_W     = 4 * DIGITS;
   localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);
   localparam logic [c_W-1:0]     c_ALL9     = {DIGITS{4'h9}};

   localparam logic [1:0] c_OP_ADD = 2'b00;
   localparam logic [1:0] c_OP_SUB = 2'b01;
   localparam logic [1:0] c_OP_MUL = 2'b10;
   localparam logic [1:0] c_OP_DIV = 2'b11;

   localparam logic [2:0] c_S_IDLE = 3'd0;
   localparam logic [2:0] c_S_LOAD = 3'd1;
   localparam logic [2:0] c_S_CMP  = 3'd2;
   localparam logic [2:0] c_S_DIG  = 3'd3;
   localparam logic [2:0] c_S_DEC  = 3'd4;
   localparam logic [2:0] c_S_DONE = 3'd5;

   // BCD increment / decrement by one, ripple across all digits.
   function automatic logic [c_W-1:0] bcd_inc(input logic [c_W-1:0] v);
      logic [c_W-1:0] r;
      logic           c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [c_W-1:0] bcd_dec(input logic [c_W-1:0] v);
      logic [c_W-1:0] r;
      logic           b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (r[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [2:0]          r_state;
   logic [2:0]          w_next;
   logic [1:0]          r_op;
   logic [c_W-1:0]      r_a;
   logic [c_W-1:0]      r_b;
   logic [c_W-1:0]      r_acc;     // accumulator / remainder, rotates during DIG
   logic [c_W-1:0]      r_opnd;    // addend / subtrahend, rotates during DIG
   logic [c_W-1:0]      r_cnt;     // multiply count-down or divide quotient
   logic                r_sub;     // adder runs in 9's-complement subtract mode
   logic                r_neg;     // subtract operands were swapped (A < B)
   logic                r_carry;   // digit-to-digit carry within a pass
   logic [c_IDX_W-1:0]  r_didx;
   logic [c_W-1:0]      r_result;
   logic                r_negative;
   logic                r_overflow;
   logic                r_error;

   // ------------------------------------------------------------------------
   // Digit-serial adder: always works on digit 0 of the rotating registers
   // ------------------------------------------------------------------------
   logic [3:0]      w_acc_d;
   logic [3:0]      w_opnd_d;
   logic            w_cin;
   logic [4:0]      w_sum;
   logic            w_gt9;
   logic [3:0]      w_dsum;
   logic            w_last;
   logic [c_W-1:0]  w_acc_rot;
   logic [c_W-1:0]  w_opnd_rot;
   logic [c_W-1:0]  w_cnt_dec;

   assign w_acc_d  = r_acc[3:0];
   assign w_opnd_d = r_sub ? (4'd9 - r_opnd[3:0]) : r_opnd[3:0];
   // In subtract mode the +1 of the 10's complement enters as digit-0 carry.
   assign w_cin    = (r_didx == '0) ? r_sub : r_carry;
   assign w_sum    = {1'b0, w_acc_d} + {1'b0, w_opnd_d} + {4'd0, w_cin};
   assign w_gt9    = (w_sum > 5'd9);
   // 4-bit wrap of (sum + 6) yields the corrected digit for sums 10..19.
   assign w_dsum   = w_gt9 ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
   assign w_last   = (r_didx == c_LAST_IDX);
   assign w_cnt_dec = bcd_dec(r_cnt);

   // Result digit enters at the top; after DIGITS cycles both registers are
   // back in their natural alignment.
   generate
      if (DIGITS == 1) begin : g_rot_single
         assign w_acc_rot  = w_dsum;
         assign w_opnd_rot = r_opnd;
      end else begin : g_rot_multi
         assign w_acc_rot  = {w_dsum, r_acc[c_W-1:4]};
         assign w_opnd_rot = {r_opnd[3:0], r_opnd[c_W-1:4]};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (start) w_next = c_S_LOAD;
         end
         c_S_LOAD: begin
            case (r_op)
               c_OP_MUL: w_next = (r_b == '0) ? c_S_DONE : c_S_DIG;
               c_OP_DIV: w_next = (r_b == '0) ? c_S_DONE : c_S_CMP;
               default:  w_next = c_S_DIG;
            endcase
         end
         c_S_CMP: begin
            w_next = (r_acc >= r_opnd) ? c_S_DIG : c_S_DONE;
         end
         c_S_DIG: begin
            if (w_last) begin
               case (r_op)
                  c_OP_MUL: w_next = w_gt9 ? c_S_DONE : c_S_DEC;
                  c_OP_DIV: w_next = c_S_CMP;
                  default:  w_next = c_S_DONE;
               endcase
            end
         end
         c_S_DEC: begin
            w_next = (w_cnt_dec == '0) ? c_S_DONE : c_S_DIG;
         end
         c_S_DONE: begin
            w_next = c_S_IDLE;
         end
         default: begin
            w_next = c_S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      busy = (r_state != c_S_IDLE);
      done = (r_state == c_S_DONE);
   end

   // Result and flags to capture, selected by the state that leads to DONE.
   logic [c_W-1:0]  w_res;
   logic            w_neg;
   logic            w_ovf;
   logic            w_err;
   logic            w_enter_done;

   assign w_enter_done = (r_state != c_S_DONE) && (w_next == c_S_DONE);

   always_comb begin
      w_res = '0;
      w_neg = 1'b0;
      w_ovf = 1'b0;
      w_err = 1'b0;
      case (r_state)
         c_S_LOAD: begin
            // Only a zero-count multiply or divide-by-zero finishes here.
            w_err = (r_op == c_OP_DIV);
         end
         c_S_DIG: begin
            if (r_op == c_OP_MUL) begin
               // Multiply leaves DIG for DONE only on a top-digit carry.
               w_res = c_ALL9;
               w_ovf = 1'b1;
            end else begin
               w_res = w_acc_rot;
               w_ovf = (r_op == c_OP_ADD) && w_gt9;
               w_neg = (r_op == c_OP_SUB) && r_neg;
            end
         end
         c_S_DEC: begin
            w_res = r_acc;
         end
         c_S_CMP: begin
            w_res = r_cnt;
         end
         default: begin
            w_res = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_op       <= 2'b00;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_opnd     <= '0;
         r_cnt      <= '0;
         r_sub      <= 1'b0;
         r_neg      <= 1'b0;
         r_carry    <= 1'b0;
         r_didx     <= '0;
         r_result   <= '0;
         r_negative <= 1'b0;
         r_overflow <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (start) begin
                  r_op <= op_code;
                  r_a  <= a_bcd;
                  r_b  <= b_bcd;
               end
            end
            c_S_LOAD: begin
               r_didx  <= '0;
               r_carry <= 1'b0;
               r_neg   <= 1'b0;
               case (r_op)
                  c_OP_ADD: begin
                     r_acc  <= r_a;
                     r_opnd <= r_b;
                     r_sub  <= 1'b0;
                  end
                  c_OP_SUB: begin
                     // Packed BCD orders like an unsigned vector.
                     r_sub <= 1'b1;
                     if (r_a < r_b) begin
                        r_acc  <= r_b;
                        r_opnd <= r_a;
                        r_neg  <= 1'b1;
                     end else begin
                        r_acc  <= r_a;
                        r_opnd <= r_b;
                     end
                  end
                  c_OP_MUL: begin
                     r_acc  <= '0;
                     r_opnd <= r_a;
                     r_cnt  <= r_b;
                     r_sub  <= 1'b0;
                  end
                  default: begin
                     r_acc  <= r_a;
                     r_opnd <= r_b;
                     r_cnt  <= '0;
                     r_sub  <= 1'b1;
                  end
               endcase
            end
            c_S_DIG: begin
               r_acc   <= w_acc_rot;
               r_opnd  <= w_opnd_rot;
               r_carry <= w_gt9;
               if (w_last) begin
                  r_didx <= '0;
                  if (r_op == c_OP_DIV) r_cnt <= bcd_inc(r_cnt);
               end else begin
                  r_didx <= r_didx + c_IDX_W'(1);
               end
            end
            c_S_DEC: begin
               r_cnt <= w_cnt_dec;
            end
            default: begin
               r_didx <= r_didx;
            end
         endcase

         if (w_enter_done) begin
            r_result   <= w_res;
            r_negative <= w_neg;
            r_overflow <= w_ovf;
            r_error    <= w_err;
         end
      end
   end

   assign result_bcd = r_result;
   assign negative   = r_negative;
   assign overflow   = r_overflow;
   assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bcd_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_alu_sequencer
// Purpose  : Directed self-checking bench for bcd_alu_sequencer (DIGITS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_alu_sequencer;

   localparam int DIGITS = 3;
   localparam int c_W    = 4 * DIGITS;

   logic             clock;
   logic             resetn;
   logic             start;
   logic [1:0]       op_code;
   logic [c_W-1:0]   a_bcd;
   logic [c_W-1:0]   b_bcd;
   logic             busy;
   logic             done;
   logic [c_W-1:0]   result_bcd;
   logic             negative;
   logic             overflow;
   logic             error;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_alu_sequencer #(.DIGITS(DIGITS)) u_dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .op_code    (op_code),
      .a_bcd      (a_bcd),
      .b_bcd      (b_bcd),
      .busy       (busy),
      .done       (done),
      .result_bcd (result_bcd),
      .negative   (negative),
      .overflow   (overflow),
      .error      (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and check latency (edges after the start edge),
   // result, flags and the single-cycle done pulse.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         input int exp_edge, input logic [c_W-1:0] exp_res,
                         input logic exp_neg, input logic exp_ovf, input logic exp_err);
      int n;
      n = 0;
      @(negedge clock);
      op_code = op;
      a_bcd   = a;
      b_bcd   = b;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      while (!done && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      check({tag, "_edge"}, 32'(n), 32'(exp_edge));
      check({tag, "_res"},  32'(result_bcd), 32'(exp_res));
      check({tag, "_neg"},  32'(negative), 32'(exp_neg));
      check({tag, "_ovf"},  32'(overflow), 32'(exp_ovf));
      check({tag, "_err"},  32'(error), 32'(exp_err));
      @(posedge clock);
      #1;
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_busy_drop"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int pulses;
      int done_edge;
      int stray;

      resetn  = 1'b0;
      start   = 1'b0;
      op_code = 2'b00;
      a_bcd   = '0;
      b_bcd   = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res",  32'(result_bcd), 32'd0);
      check("rst_flags", 32'({negative, overflow, error}), 32'd0);
      @(negedge clock);
      resetn = 1'b1;

      // Add
      run_op("add1", 2'b00, 12'h456, 12'h321, 4, 12'h777, 1'b0, 1'b0, 1'b0);
      run_op("add2", 2'b00, 12'h999, 12'h001, 4, 12'h000, 1'b0, 1'b1, 1'b0);
      // Subtract
      run_op("sub1", 2'b01, 12'h123, 12'h456, 4, 12'h333, 1'b1, 1'b0, 1'b0);
      run_op("sub2", 2'b01, 12'h456, 12'h123, 4, 12'h333, 1'b0, 1'b0, 1'b0);
      run_op("sub3", 2'b01, 12'h250, 12'h250, 4, 12'h000, 1'b0, 1'b0, 1'b0);
      // Multiply: 1 + 4*13 = 53; 500*2 overflows at end of second pass (edge 8)
      run_op("mul1", 2'b10, 12'h012, 12'h013, 53, 12'h156, 1'b0, 1'b0, 1'b0);
      run_op("mul2", 2'b10, 12'h500, 12'h002, 8, 12'h999, 1'b0, 1'b1, 1'b0);
      run_op("mul3", 2'b10, 12'h777, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
      // Divide: 2 + 4*14 = 58
      run_op("div1", 2'b11, 12'h100, 12'h007, 58, 12'h014, 1'b0, 1'b0, 1'b0);
      run_op("div2", 2'b11, 12'h005, 12'h009, 2, 12'h000, 1'b0, 1'b0, 1'b0);
      run_op("div3", 2'b11, 12'h123, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b1);

      // start during a multiply and during DONE is ignored.
      pulses    = 0;
      done_edge = -1;
      @(negedge clock);
      op_code = 2'b10;
      a_bcd   = 12'h002;
      b_bcd   = 12'h003;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clock);
         #1;
         if (done_edge > 0 && e == done_edge + 1) begin
            check("ign_busy_drop", 32'(busy), 32'd0);
            start = 1'b0;
         end
         if (e == 5) begin
            start   = 1'b1;
            op_code = 2'b00;
            a_bcd   = 12'h999;
            b_bcd   = 12'h999;
         end
         if (e == 6) start = 1'b0;
         if (done) begin
            pulses++;
            done_edge = e;
            start     = 1'b1;
         end
      end
      start = 1'b0;
      check("ign_pulses", 32'(pulses), 32'd1);
      check("ign_edge",   32'(done_edge), 32'd13);
      check("ign_res",    32'(result_bcd), 32'h006);
      check("ign_ovf",    32'(overflow), 32'd0);

      // Reset in the middle of a multiply.
      stray = 0;
      @(negedge clock);
      op_code = 2'b10;
      a_bcd   = 12'h012;
      b_bcd   = 12'h013;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clock);
         #1;
      end
      #1;
      resetn = 1'b0;
      #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_res",  32'(result_bcd), 32'd0);
      check("mrst_flags", 32'({negative, overflow, error}), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      for (int e = 0; e < 60; e++) begin
         @(posedge clock);
         #1;
         if (done || busy) stray++;
      end
      check("mrst_no_done", 32'(stray), 32'd0);

      run_op("add3", 2'b00, 12'h001, 12'h002, 4, 12'h003, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
